// File: rtl/fb_pkg.sv
// Shared definitions for the ping-pong frame buffer: default geometry,
// control state encoding and the pixel type.
package fb_pkg;

  localparam int COL_W   = 7;
  localparam int ROW_W   = 6;
  localparam int PIX_W   = 12;
  localparam int ADDR_W  = COL_W + ROW_W;
  localparam int STALE_W = 8;

  // FILL: tracer may write the back bank. WAIT_SWAP: a complete frame is
  // parked in the back bank until the next VGA frame boundary.
  typedef enum logic {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } fb_state_e;

  // {b,g,r} 4:4:4 colour, r in [3:0]
  typedef logic [PIX_W-1:0] pixel_t;

endpackage

// File: rtl/fb_bank.sv
// Simple dual-port RAM: one write port, one synchronous read port.
module fb_bank #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd_q
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Write on the accepting edge; registered read when strobed.
  // NOTE: the array and read register have no reset, so the tools can map
  // them onto block RAM; consumers must gate rd_q with their own valid.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd_q <= mem[ra];
  end

endmodule

// File: rtl/pingpong_fb.sv
// Ping-pong frame buffer between the ray tracer (writer) and VGA scan-out
// (reader). The back bank is filled until wr_last, then parked until a VGA
// frame_start swaps the banks, so a half-traced frame is never shown.
module pingpong_fb #(
  parameter int COL_W = fb_pkg::COL_W,
  parameter int ROW_W = fb_pkg::ROW_W,
  parameter int PIX_W = fb_pkg::PIX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [COL_W-1:0] wr_col,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [PIX_W-1:0] wr_data,
  input  logic             wr_last,
  input  logic             frame_start,
  input  logic             rd_en,
  input  logic [COL_W-1:0] rd_col,
  input  logic [ROW_W-1:0] rd_row,
  output logic [PIX_W-1:0] rd_data,
  output logic             rd_valid,
  output logic             front_sel,
  output logic             swap_pulse,
  output logic [7:0]       stale_cnt
);

  import fb_pkg::*;

  localparam int AW = COL_W + ROW_W;

  fb_state_e state_q, state_d;
  logic      wr_fire;
  logic      swap_d;
  logic      shown_q;
  logic      rd_valid_q;
  logic      rd_sel_q;
  logic      rd_shown_q;
  logic [7:0] stale_q;

  logic [AW-1:0]    wr_addr, rd_addr;
  logic [PIX_W-1:0] q0, q1;

  assign wr_addr = {wr_row, wr_col};
  assign rd_addr = {rd_row, rd_col};

  // Next-state, write handshake and swap decision.
  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b0;
    wr_fire  = 1'b0;
    swap_d   = 1'b0;
    unique case (state_q)
      FILL: begin
        wr_ready = ~rst;
        wr_fire  = wr_valid & ~rst;
        if (wr_fire && wr_last) state_d = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (frame_start) begin
          swap_d  = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Control registers: state, displayed bank, shown flag, staleness counter.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FILL;
      front_sel  <= 1'b0;
      swap_pulse <= 1'b0;
      shown_q    <= 1'b0;
      stale_q    <= '0;
    end else begin
      state_q    <= state_d;
      swap_pulse <= swap_d;
      if (swap_d) begin
        front_sel <= ~front_sel;
        shown_q   <= 1'b1;
        stale_q   <= '0;
      end else if (frame_start && stale_q != 8'hFF) begin
        stale_q <= stale_q + 8'd1;
      end
    end
  end

  // Read-side pipeline: remember which bank and blanking state the read saw.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_sel_q   <= 1'b0;
      rd_shown_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      rd_sel_q   <= front_sel;
      rd_shown_q <= shown_q;
    end
  end

  // Writes target the back bank, reads the front; both see the same address.
  fb_bank #(.ADDR_W(AW), .DATA_W(PIX_W)) u_bank0 (
    .clk  (clk),
    .we   (wr_fire & front_sel),
    .wa   (wr_addr),
    .wd   (wr_data),
    .re   (rd_en),
    .ra   (rd_addr),
    .rd_q (q0)
  );

  fb_bank #(.ADDR_W(AW), .DATA_W(PIX_W)) u_bank1 (
    .clk  (clk),
    .we   (wr_fire & ~front_sel),
    .wa   (wr_addr),
    .wd   (wr_data),
    .re   (rd_en),
    .ra   (rd_addr),
    .rd_q (q1)
  );

  assign rd_valid  = rd_valid_q;
  assign rd_data   = (rd_valid_q && rd_shown_q) ? (rd_sel_q ? q1 : q0) : '0;
  assign stale_cnt = stale_q;

endmodule

// File: tb/tb_pingpong_fb.sv
// Self-checking bench for pingpong_fb: directed scenarios plus random traffic
// compared against a frame-level reference model (two pixel arrays, the
// displayed bank, a "frame parked" flag and a staleness count).
module tb_pingpong_fb;

  import fb_pkg::*;

  localparam int DEPTH = 1 << ADDR_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_valid;
  logic             wr_ready;
  logic [COL_W-1:0] wr_col;
  logic [ROW_W-1:0] wr_row;
  pixel_t           wr_data;
  logic             wr_last;
  logic             frame_start;
  logic             rd_en;
  logic [COL_W-1:0] rd_col;
  logic [ROW_W-1:0] rd_row;
  pixel_t           rd_data;
  logic             rd_valid;
  logic             front_sel;
  logic             swap_pulse;
  logic [7:0]       stale_cnt;

  pingpong_fb dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_col      (wr_col),
    .wr_row      (wr_row),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .frame_start (frame_start),
    .rd_en       (rd_en),
    .rd_col      (rd_col),
    .rd_row      (rd_row),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .front_sel   (front_sel),
    .swap_pulse  (swap_pulse),
    .stale_cnt   (stale_cnt)
  );

  always #5 clk = ~clk;

  // Reference model
  pixel_t m_mem   [2][DEPTH];
  bit     m_known [2][DEPTH];
  bit     m_front;
  bit     m_shown;
  bit     m_parked;
  int     m_stale;
  bit     e_swap;
  bit     e_rv;
  pixel_t e_rd;
  bit     e_known;
  bit     last_fire;
  bit     rd_rand;

  int n_vec;
  int n_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: check the handshake before the edge, advance the model at the
  // edge, check registered outputs just after it, return at the falling edge.
  task automatic step();
    int  a;
    bit  rdy;
    bit  back;
    if (rd_rand) begin
      rd_en  = 1'($urandom_range(0, 1));
      rd_col = COL_W'($urandom);
      rd_row = ROW_W'($urandom);
    end
    #1;
    rdy = !rst && !m_parked;
    check("wr_ready", 32'(wr_ready), 32'(rdy));
    @(posedge clk);
    last_fire = 1'b0;
    if (rst) begin
      m_front  = 1'b0;
      m_shown  = 1'b0;
      m_parked = 1'b0;
      m_stale  = 0;
      e_swap   = 1'b0;
      e_rv     = 1'b0;
      e_rd     = '0;
      e_known  = 1'b1;
    end else begin
      a = int'({rd_row, rd_col});
      e_rv    = rd_en;
      e_rd    = '0;
      e_known = 1'b1;
      if (rd_en && m_shown) begin
        e_rd    = m_mem[m_front][a];
        e_known = m_known[m_front][a];
      end
      if (wr_valid && rdy) begin
        a    = int'({wr_row, wr_col});
        back = ~m_front;
        m_mem[back][a]   = wr_data;
        m_known[back][a] = 1'b1;
        last_fire = 1'b1;
      end
      e_swap = 1'b0;
      if (frame_start && m_parked) begin
        e_swap   = 1'b1;
        m_front  = ~m_front;
        m_shown  = 1'b1;
        m_parked = 1'b0;
        m_stale  = 0;
      end else if (frame_start && m_stale < 255) begin
        m_stale++;
      end
      if (last_fire && wr_last) m_parked = 1'b1;
    end
    #1;
    check("swap_pulse", 32'(swap_pulse), 32'(e_swap));
    check("front_sel", 32'(front_sel), 32'(m_front));
    check("stale_cnt", 32'(stale_cnt), 32'(m_stale));
    check("rd_valid", 32'(rd_valid), 32'(e_rv));
    if (e_known) check("rd_data", 32'(rd_data), 32'(e_rd));
    @(negedge clk);
  endtask

  // Present one pixel and hold it until accepted (bounded).
  task automatic push(input int addr, input pixel_t d, input bit last, input bit fs);
    int guard;
    guard       = 0;
    wr_valid    = 1'b1;
    wr_col      = COL_W'(addr);
    wr_row      = ROW_W'(addr >> COL_W);
    wr_data     = d;
    wr_last     = last;
    frame_start = fs;
    do begin
      step();
      frame_start = 1'b0;
      guard++;
    end while (!last_fire && guard < 200);
    if (!last_fire) check("push_accept", 32'(last_fire), 32'd1);
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic fill(input int n, input bit addr_data, input bit with_last);
    for (int i = 0; i < n; i++)
      push(i, addr_data ? pixel_t'(i) : pixel_t'($urandom), with_last && (i == n - 1), 1'b0);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    n_vec = 0; n_bad = 0;
    rst = 1'b1; wr_valid = 1'b1; wr_col = '0; wr_row = '0; wr_data = '0;
    wr_last = 1'b0; frame_start = 1'b0; rd_en = 1'b0; rd_col = '0; rd_row = '0;
    rd_rand = 1'b1;
    m_front = 0; m_shown = 0; m_parked = 0; m_stale = 0;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < DEPTH; i++) m_known[b][i] = 1'b0;
    @(negedge clk);

    // Reset: wr_ready held low even with a pixel offered
    idle(3);
    rst = 1'b0; wr_valid = 1'b0;
    #1;
    check("post_rst_ready", 32'(wr_ready), 32'd1);
    check("post_rst_front", 32'(front_sel), 32'd0);
    check("post_rst_stale", 32'(stale_cnt), 32'd0);
    check("post_rst_rd_valid", 32'(rd_valid), 32'd0);
    @(negedge clk);

    // Pre-swap blanking with both banks preloaded behind the design's back
    dut.u_bank0.mem[0] = 12'hABC;
    dut.u_bank1.mem[0] = 12'h5A5;
    m_mem[0][0] = 12'hABC; m_known[0][0] = 1'b1;
    m_mem[1][0] = 12'h5A5; m_known[1][0] = 1'b1;
    rd_rand = 1'b0; rd_en = 1'b1; rd_col = '0; rd_row = '0;
    step();
    check("blank_rd_data", 32'(rd_data), 32'd0);
    check("blank_rd_valid", 32'(rd_valid), 32'd1);
    rd_rand = 1'b1;

    // Full frame, data = address, then swap
    fill(DEPTH, 1'b1, 1'b1);
    pulse_fs();
    check("fill_swap_pulse", 32'(swap_pulse), 32'd1);
    check("fill_front", 32'(front_sel), 32'd1);
    step();
    check("fill_swap_once", 32'(swap_pulse), 32'd0);
    rd_rand = 1'b0; rd_en = 1'b1; rd_row = 6'd5; rd_col = 7'd9;
    step();
    check("rd_5_9", 32'(rd_data), 32'h289);
    rd_en = 1'b0;
    step();
    check("no_rd_valid", 32'(rd_valid), 32'd0);
    check("no_rd_data", 32'(rd_data), 32'd0);
    rd_rand = 1'b1;

    // Backpressure: held pixel after wr_last
    fill(16, 1'b0, 1'b1);
    wr_valid = 1'b1; wr_col = 7'd3; wr_row = '0; wr_data = 12'hF0F; wr_last = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_ready", 32'(wr_ready), 32'd0);
    end
    pulse_fs();
    check("bp_swap", 32'(swap_pulse), 32'd1);
    check("held_ready", 32'(wr_ready), 32'd1);
    step();
    check("held_accept", 32'(last_fire), 32'd1);
    wr_valid = 1'b0;
    rd_rand = 1'b0; rd_en = 1'b1; rd_col = 7'd3; rd_row = '0;
    step();
    rd_rand = 1'b1;

    // Coincident wr_last acceptance and frame_start
    fill(3, 1'b0, 1'b0);
    push(3, pixel_t'($urandom), 1'b1, 1'b1);
    check("co_no_swap", 32'(swap_pulse), 32'd0);
    check("co_stale", 32'(stale_cnt), 32'd1);
    idle(3);
    pulse_fs();
    check("co_late_swap", 32'(swap_pulse), 32'd1);
    check("co_stale_clr", 32'(stale_cnt), 32'd0);

    // Staleness: frame never completes
    fill(5, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) pulse_fs();
    check("stale_sat", 32'(stale_cnt), 32'd255);
    push(5, pixel_t'($urandom), 1'b1, 1'b0);
    pulse_fs();
    check("stale_swap", 32'(swap_pulse), 32'd1);
    check("stale_clr", 32'(stale_cnt), 32'd0);

    // Mid-frame reset after 1000 writes
    fill(1000, 1'b0, 1'b0);
    rst = 1'b1; wr_valid = 1'b1;
    step();
    check("mid_rst_front", 32'(front_sel), 32'd0);
    check("mid_rst_stale", 32'(stale_cnt), 32'd0);
    check("mid_rst_swap", 32'(swap_pulse), 32'd0);
    check("mid_rst_rd_valid", 32'(rd_valid), 32'd0);
    rst = 1'b0; wr_valid = 1'b0;
    rd_rand = 1'b0; rd_en = 1'b1; rd_col = 7'd9; rd_row = 6'd5;
    step();
    check("mid_rst_blank", 32'(rd_data), 32'd0);
    rd_rand = 1'b1;
    fill(DEPTH, 1'b0, 1'b1);
    pulse_fs();
    check("mid_rst_swap_ok", 32'(swap_pulse), 32'd1);
    check("mid_rst_front_ok", 32'(front_sel), 32'd1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      wr_valid    = ($urandom_range(0, 3) != 0);
      wr_col      = COL_W'($urandom);
      wr_row      = ROW_W'($urandom_range(0, 3));
      wr_data     = pixel_t'($urandom);
      wr_last     = ($urandom_range(0, 63) == 0);
      frame_start = ($urandom_range(0, 39) == 0);
      step();
    end
    wr_valid = 1'b0; wr_last = 1'b0; frame_start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pingpong_fb.md
# pingpong_fb

Ping-pong frame buffer between the ray tracer host (producer) and the VGA scan-out (consumer). Holds two 128x64 block frames of 12-bit colour. The tracer fills the back bank while VGA reads the front bank. The banks swap only at a VGA frame boundary after the tracer has delivered a complete frame, so the display never shows a half-traced frame.

## Interface
Parameters:
- COL_W, 7, block column address width (128 columns)
- ROW_W, 6, block row address width (64 rows)
- PIX_W, 12, pixel width ({b,g,r} 4:4:4, r in [3:0])

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  single clock; the VGA side uses it with rd_en as its pixel strobe
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  tracer presents a pixel
- wr_ready  out  1  buffer accepts a pixel this cycle
- wr_col  in  COL_W  write block column
- wr_row  in  ROW_W  write block row
- wr_data  in  PIX_W  write pixel
- wr_last  in  1  qualifies the final pixel of a frame
- frame_start  in  1  one-cycle pulse from VGA at start of vertical blank
- rd_en  in  1  VGA read strobe
- rd_col  in  COL_W  read block column
- rd_row  in  ROW_W  read block row
- rd_data  out  PIX_W  pixel from front bank
- rd_valid  out  1  rd_data corresponds to the previous cycle's rd_en
- front_sel  out  1  bank currently displayed
- swap_pulse  out  1  one cycle high on the edge that toggles front_sel
- stale_cnt  out  8  frame_start pulses since the last swap, saturating

## Operation
- Storage: two banks of 2^(COL_W+ROW_W) x PIX_W; address is {row,col}.
  - Writes go to bank ~front_sel. Reads come from bank front_sel.
  - Memory contents are not reset.
- State machine, two states: FILL and WAIT_SWAP.
  - FILL: wr_ready=1. A transfer happens when wr_valid && wr_ready.
  - An accepted transfer with wr_last=1 moves the state to WAIT_SWAP.
  - WAIT_SWAP: wr_ready=0. wr_valid is ignored and the tracer holds its pixel.
  - frame_start in WAIT_SWAP: front_sel toggles, swap_pulse=1, state returns to FILL, stale_cnt clears to 0, shown flag is set.
- shown flag: cleared by reset and set on the first swap. While it is clear, rd_data=0, so uninitialised memory is never displayed.
- stale_cnt: increments on every frame_start that does not cause a swap; saturates at 255.
- Address order within a frame is not checked; wr_last alone delimits frames. A missing wr_last stalls swaps indefinitely, and stale_cnt reports this.

## Timing
- Reset values: wr_ready=0 during rst and 1 on the first cycle after; front_sel=0; swap_pulse=0; stale_cnt=0; rd_data=0; rd_valid=0; state FILL; shown=0.
- Write latency: data is written at the accepting edge.
- Read latency: 1 cycle.
  - rd_en at cycle N gives rd_data and rd_valid=1 at N+1.
  - Without rd_en, the next cycle has rd_valid=0 and rd_data=0.
- Stall after last pixel: wr_last accepted at edge N gives wr_ready=0 from N+1.
- Swap timing: frame_start in WAIT_SWAP at cycle M.
  - front_sel toggles and swap_pulse=1 at M+1.
  - wr_ready=1 at M+1.
- frame_start in the same cycle that wr_last is accepted: no swap. The swap waits for the next frame_start, and stale_cnt increments.
- Read in the swap cycle M uses the pre-toggle front_sel.
- Reads and writes to the same {row,col} never conflict because they target different banks.
- rst asserted mid-frame: all outputs return to reset values on the next edge, and the partial frame is discarded (shown=0 again).

## Structure
- Shared package fb_pkg holds:
  - COL_W, ROW_W, PIX_W defaults and the derived ADDR_W=COL_W+ROW_W
  - the state enum {FILL, WAIT_SWAP}
  - the pixel typedef
- One sub-module, fb_bank: a simple dual-port RAM with synchronous read, one write port and one read port, instantiated twice.
- pingpong_fb contains the control FSM, the bank muxing, the shown flag and stale_cnt.

## Test plan
- Reset then fill: write all 8192 pixels with data = addr[11:0], wr_last on {63,127}, then pulse frame_start.
  - Expect swap_pulse one cycle and front_sel=1.
  - Reads of {5,9} return 12'h289 one cycle later.
- Pre-swap blanking: after reset, rd_en at {0,0} with bank 1 preloaded by backdoor -> rd_data=0, rd_valid=1.
- Backpressure: after wr_last is accepted, hold wr_valid=1 for 20 cycles.
  - Expect wr_ready=0 throughout and no writes to either bank.
  - After frame_start, the held pixel is accepted on the first cycle.
- Coincident event: frame_start in the same cycle as the wr_last acceptance.
  - Expect no swap and stale_cnt=1.
  - The swap happens on the next frame_start.
- Staleness: 300 frame_starts with no wr_last -> stale_cnt=255; the next completed frame plus frame_start clears it to 0.
- Mid-frame reset: assert rst after 1000 writes.
  - All outputs return to reset values and front_sel=0.
  - A subsequent full frame swaps normally.
